hjscope: RTL and testbench
==========================

Name: hjscope

Overview:
- Parametrised logic-analyser capture block: samples an N-bit probe bus into a SIZ-deep circular buffer.
- Triggers on a programmable per-bit mask/value/edge match rather than a fixed LUT.
- Stops after a programmable post-trigger count, then exposes the buffer oldest-first through 32-bit register reads.
- Sits on the shared debug register bus beside other debug peripherals; next generation of the existing analyser, adding a sample-rate divider, edge triggers, a forced trigger and a valid-sample count.

Parameters:
N, 32, probe width in bits, 1..1024; W = ceil(N/32) 32-bit slices per sample.
SIZ, 1024, buffer depth in samples, 2..32768.

Ports:
clk  in  1  clock, all logic rising-edge.
rst  in  1  synchronous active-high reset.
regreq  in  1  register access strobe, one cycle.
regwr  in  1  1 = write, 0 = read; valid with regreq.
regaddr  in  12  byte address; decode uses regaddr & ~3.
regwdata  in  32  write data.
regack  out  1  one-cycle completion pulse.
regerr  out  1  error flag, valid with regack.
regrdata  out  32  read data, valid with regack.
in  in  N  probe bus.

Behaviour:
- Reset: all outputs 0; state IDLE; all registers 0. A zero MASK makes the trigger unconditionally true.
- Register map:
  - 0x00 CTRL. W: bit0 start, bit1 abort, bit8 trans, bit9 force, [31:16] POST. R: {POST, 6'b0, force, trans, 8'b0}.
  - 0x04 INFO, R: {N[15:0], SIZ[15:0]}.
  - 0x08 DATA, R: next slice, see readout.
  - 0x0C SEL, R/W: slice index k, 0..W-1.
  - 0x10 MASK[k], 0x14 VALUE[k], 0x18 EDGE[k], R/W.
  - 0x1C DIV, R/W: [15:0].
  - 0x20 STATUS, R: {cnt[15:0], 12'b0, triggered, running, avail, 1'b0}.
- Access errors: SEL >= W, write to a read-only address, or an unmapped address → regerr=1. A write with SEL out of range is discarded.
- Ack latency: regack follows regreq by 1 cycle for every access except DATA, which acks after exactly 3 cycles. A regreq arriving while a DATA read is pending is undefined.
- Sample strobe: a divider counter emits tick once every DIV+1 cycles. Probe is registered into s; s0 holds the previous ticked s.
- Trigger per bit: MASK=0, or (s==VALUE and (EDGE=0 or s!=s0)). trig = AND over all N bits, or force=1. force holds until the next CTRL write.
- Write enable on tick in ARMED/POST: when trans=0, always. When trans=1, only if s != last stored sample, or no sample has been stored yet this run.
- Each write stores s at wptr; wptr wraps SIZ-1→0; cnt saturates at SIZ.
- States:
  - IDLE → ARMED on start.
  - ARMED: on tick with trig, set triggered, store the sample even if trans suppresses it, load pc=min(POST,SIZ-1). If pc=0 go to DONE, else POST.
  - POST: each stored sample decrements pc; pc reaching 0 → DONE.
  - DONE: avail=1, running=0, rptr=(cnt<SIZ ? 0 : wptr), slice counter 0.
- running=1 in ARMED and POST.
- start in any state: clear cnt, wptr, triggered, avail, divider; go to ARMED.
- abort: go to IDLE, avail=0; buffer contents kept but unreadable.
- start and abort in the same write: start wins.
- Readout (avail=1): a DATA read returns sample bits [32k+31:32k] for slice k = 0..W-1 in order, zero-padding above N. After slice W-1 the slice counter clears and rptr advances with wrap.
- Reads beyond cnt samples, or with avail=0: regerr=1, data 0. Readout does not disturb capture registers.
- Widths: cnt, wptr and rptr are 16 bits. POST is clamped, never wrapped.

Test Plan:
- N=8, SIZ=16, in counts 0,1,2… per cycle; MASK=0xFF, VALUE=0x20, POST=3 → after trigger, cnt=16 and readout gives 0x14..0x23 in order.
- N=40, SIZ=8, trans=1, in changes every 5 cycles, force=1, POST=7 → 8 samples, 16 DATA reads, each alternating {low32, 8-bit upper zero-padded}.
- EDGE=1 on bit0, VALUE=1, in bit0 held at 1 from arming → no trigger; first 0→1 transition triggers.
- DIV=3, force, POST=4 → stored samples are exactly 4 cycles apart; POST=40000 with SIZ=16 clamps to 15 post samples.
- Abort during POST → STATUS avail=0, running=0; DATA read returns regerr=1. Reset mid-capture → all outputs 0, state IDLE.
- SEL=W, write MASK → regerr=1, stored masks unchanged; read 0x24 → regerr=1; INFO read returns {N, SIZ}.

Source files
------------

// File: rtl/hjscope.sv
// hjscope: logic-analyser capture with mask/value/edge trigger and oldest-first register readout
module hjscope #(
  parameter int N = 32,
  parameter int SIZ = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic regreq,
  input  logic regwr,
  input  logic [11:0] regaddr,
  input  logic [31:0] regwdata,
  output logic regack,
  output logic regerr,
  output logic [31:0] regrdata,
  input  logic [N-1:0] in
);
  localparam int W = (N + 31) / 32;
  localparam int SW = W > 1 ? $clog2(W) : 1;
  localparam int AW = $clog2(SIZ);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} st_t;
  st_t st;
  logic [W-1:0][31:0] mem [SIZ];
  logic [W-1:0][31:0] s, s0, last, rq, mask, value, edg;
  logic [31:0] sel, crd;
  logic [15:0] div, dcnt, post, pc, cnt, wptr, rptr, rnum, cnt_n, wptr_n, pcl;
  logic trans, frc, triggered, avail, stored;
  logic [1:0] dp;
  logic [SW-1:0] slc, k;
  logic [N-1:0] ok;
  logic [11:0] a;
  logic tick, run, trig, hit, we, fin, selok, rd_data, cerr, derr, last_slc;
  always_comb begin
    a = regaddr & 12'hFFC;
    k = sel[SW-1:0];
    selok = sel < 32'(W);
    tick = dcnt == div;
    run = st == ARMED || st == POST;
    ok = N'(~mask | (~(s ^ value) & (~edg | (s ^ s0))));
    trig = &ok || frc;
    hit = st == ARMED && tick && trig;
    we = hit || (run && tick && (!trans || !stored || s != last));
    cnt_n = cnt + 16'(we && cnt < 16'(SIZ));
    wptr_n = !we ? wptr : wptr == 16'(SIZ - 1) ? '0 : wptr + 1'b1;
    pcl = post > 16'(SIZ - 1) ? 16'(SIZ - 1) : post;
    fin = (hit && pcl == '0) || (st == POST && we && pc == 16'd1);
    rd_data = regreq && !regwr && a == 12'h008;
    derr = !avail || rnum >= cnt;
    last_slc = slc == SW'(W - 1);
    crd = '0;
    cerr = 1'b0;
    case (a)
      12'h000: crd = {post, 6'b0, frc, trans, 8'b0};
      12'h004: begin crd = {16'(N), 16'(SIZ)}; cerr = regwr; end
      12'h008: cerr = 1'b1;
      12'h00C: crd = sel;
      12'h010: begin crd = selok ? mask[k] : '0; cerr = !selok; end
      12'h014: begin crd = selok ? value[k] : '0; cerr = !selok; end
      12'h018: begin crd = selok ? edg[k] : '0; cerr = !selok; end
      12'h01C: crd = {16'b0, div};
      12'h020: begin crd = {cnt, 12'b0, triggered, run, avail, 1'b0}; cerr = regwr; end
      default: cerr = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (we) mem[wptr[AW-1:0]] <= s;
    rq <= mem[rptr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      {s, s0, last, mask, value, edg} <= '0;
      {sel, div, dcnt, post, pc, cnt, wptr, rptr, rnum} <= '0;
      {trans, frc, triggered, avail, stored, dp, slc} <= '0;
      {regack, regerr, regrdata} <= '0;
    end else begin
      s <= (W * 32)'(in);
      dcnt <= tick ? '0 : dcnt + 1'b1;
      if (tick) s0 <= s;
      if (we) begin
        last <= s;
        stored <= 1'b1;
      end
      cnt <= cnt_n;
      wptr <= wptr_n;
      if (hit) begin
        triggered <= 1'b1;
        pc <= pcl;
        st <= POST;
      end
      if (st == POST && we) pc <= pc - 1'b1;
      if (fin) begin
        st <= DONE;
        avail <= 1'b1;
        rptr <= cnt_n < 16'(SIZ) ? '0 : wptr_n;
        slc <= '0;
        rnum <= '0;
      end
      regack <= 1'b0;
      regerr <= 1'b0;
      regrdata <= '0;
      if (regreq && !rd_data) begin
        regack <= 1'b1;
        regerr <= cerr;
        regrdata <= (cerr || regwr) ? '0 : crd;
        if (regwr && !cerr)
          case (a)
            12'h000: begin
              trans <= regwdata[8];
              frc <= regwdata[9];
              post <= regwdata[31:16];
              if (regwdata[1]) begin
                st <= IDLE;
                avail <= 1'b0;
              end
              if (regwdata[0]) begin
                st <= ARMED;
                {cnt, wptr, dcnt} <= '0;
                {triggered, avail, stored} <= '0;
              end
            end
            12'h00C: sel <= regwdata;
            12'h010: mask[k] <= regwdata;
            12'h014: value[k] <= regwdata;
            12'h018: edg[k] <= regwdata;
            12'h01C: div <= regwdata[15:0];
            default: ;
          endcase
      end
      if (rd_data) dp <= 2'd2;
      if (dp == 2'd2) dp <= 2'd1;
      if (dp == 2'd1) begin
        dp <= '0;
        regack <= 1'b1;
        regerr <= derr;
        regrdata <= derr ? '0 : rq[slc];
        if (!derr) begin
          slc <= last_slc ? '0 : slc + 1'b1;
          if (last_slc) begin
            rnum <= rnum + 1'b1;
            rptr <= rptr == 16'(SIZ - 1) ? '0 : rptr + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hjscope.sv
// tb_hjscope: directed checks of capture, trigger, readout and register errors on two hjscope configurations
module tb_hjscope;
  logic clk = 0, rst = 1;
  logic req8 = 0, req40 = 0, wr = 0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [7:0] in8 = '0;
  logic [39:0] in40 = '0;
  logic ack8, err8, ack40, err40;
  logic [31:0] rd8, rd40;
  int npass = 0, ntot = 0;
  always #5 clk = ~clk;
  hjscope #(.N(8), .SIZ(16)) d8 (.clk(clk), .rst(rst), .regreq(req8), .regwr(wr), .regaddr(addr),
    .regwdata(wdata), .regack(ack8), .regerr(err8), .regrdata(rd8), .in(in8));
  hjscope #(.N(40), .SIZ(8)) d40 (.clk(clk), .rst(rst), .regreq(req40), .regwr(wr), .regaddr(addr),
    .regwdata(wdata), .regack(ack40), .regerr(err40), .regrdata(rd40), .in(in40));
  task automatic acc(input bit d, input bit w, input logic [11:0] ad, input logic [31:0] wd,
                     output logic e, output logic [31:0] rd, output int lat);
    @(negedge clk);
    wr = w; addr = ad; wdata = wd;
    if (d) req40 = 1; else req8 = 1;
    @(negedge clk);
    req8 = 0; req40 = 0;
    lat = 1;
    while (!(d ? ack40 : ack8) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    e = d ? err40 : err8;
    rd = d ? rd40 : rd8;
  endtask
  task automatic wreg(input bit d, input logic [11:0] ad, input logic [31:0] wd);
    logic e; logic [31:0] rd; int lat;
    acc(d, 1, ad, wd, e, rd, lat);
  endtask
  task automatic test_reset;
    logic e; logic [31:0] rd; int lat;
    rst = 1;
    repeat (3) @(negedge clk);
    ntot++; if ({ack8, err8, rd8, ack40, err40, rd40} !== 66'b0) $display("FAIL reset_outputs: got %b %b %h %b %b %h want all 0", ack8, err8, rd8, ack40, err40, rd40); else npass++;
    rst = 0;
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 0 || lat != 1) $display("FAIL reset_status: got err=%b data=%h lat=%0d want 0 0 1", e, rd, lat); else npass++;
    acc(0, 0, 12'h000, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 0) $display("FAIL reset_ctrl: got err=%b data=%h want 0 0", e, rd); else npass++;
  endtask
  task automatic test_info;
    logic e; logic [31:0] rd; int lat;
    acc(0, 0, 12'h004, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0008_0010 || lat != 1) $display("FAIL info8: got err=%b data=%h lat=%0d want 0 00080010 1", e, rd, lat); else npass++;
    acc(1, 0, 12'h005, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0028_0008) $display("FAIL info40: got err=%b data=%h want 0 00280008", e, rd); else npass++;
  endtask
  task automatic test_count;
    logic e; logic [31:0] rd; int lat;
    wreg(0, 12'h010, 32'hFF);
    wreg(0, 12'h014, 32'h20);
    wreg(0, 12'h000, 32'h0003_0001);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in8 = 8'(i);
    end
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0010_000A) $display("FAIL count_status: got err=%b data=%h want 0 0010000a", e, rd); else npass++;
    for (int i = 0; i < 16; i++) begin
      acc(0, 0, 12'h008, 0, e, rd, lat);
      ntot++; if (e !== 0 || rd !== 32'h14 + i || lat != 3) $display("FAIL count_data[%0d]: got err=%b data=%h lat=%0d want 0 %h 3", i, e, rd, lat, 32'h14 + i); else npass++;
    end
    acc(0, 0, 12'h008, 0, e, rd, lat);
    ntot++; if (e !== 1 || rd !== 0) $display("FAIL count_overread: got err=%b data=%h want 1 0", e, rd); else npass++;
  endtask
  task automatic test_trans;
    logic e; logic [31:0] rd, want; int lat;
    in40 = {8'h50, 32'hC0DE0000};
    repeat (3) @(negedge clk);
    wreg(1, 12'h000, 32'h0007_0301);
    for (int i = 1; i < 8; i++) begin
      repeat (5) @(negedge clk);
      in40 = {8'(8'h50 + i), 32'hC0DE0000 + i};
    end
    repeat (10) @(negedge clk);
    acc(1, 0, 12'h000, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0007_0300) $display("FAIL trans_ctrl: got err=%b data=%h want 0 00070300", e, rd); else npass++;
    acc(1, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0008_000A) $display("FAIL trans_status: got err=%b data=%h want 0 0008000a", e, rd); else npass++;
    for (int i = 0; i < 16; i++) begin
      want = (i % 2 == 0) ? 32'hC0DE0000 + i / 2 : 32'h50 + i / 2;
      acc(1, 0, 12'h008, 0, e, rd, lat);
      ntot++; if (e !== 0 || rd !== want || lat != 3) $display("FAIL trans_data[%0d]: got err=%b data=%h lat=%0d want 0 %h 3", i, e, rd, lat, want); else npass++;
    end
  endtask
  task automatic test_edge;
    logic e; logic [31:0] rd, want; int lat;
    in8 = 8'h01;
    wreg(0, 12'h010, 32'h1);
    wreg(0, 12'h014, 32'h1);
    wreg(0, 12'h018, 32'h1);
    wreg(0, 12'h000, 32'h1);
    repeat (20) @(negedge clk);
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0010_0004) $display("FAIL edge_held: got err=%b data=%h want 0 00100004", e, rd); else npass++;
    in8 = 8'h00;
    repeat (3) @(negedge clk);
    in8 = 8'h03;
    repeat (5) @(negedge clk);
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0010_000A) $display("FAIL edge_trig: got err=%b data=%h want 0 0010000a", e, rd); else npass++;
    for (int i = 0; i < 16; i++) begin
      want = i == 15 ? 32'h3 : i >= 12 ? 32'h0 : 32'h1;
      acc(0, 0, 12'h008, 0, e, rd, lat);
      ntot++; if (e !== 0 || rd !== want) $display("FAIL edge_data[%0d]: got err=%b data=%h want 0 %h", i, e, rd, want); else npass++;
    end
  endtask
  task automatic test_div;
    logic e; logic [31:0] rd; int lat;
    logic [7:0] prev, first;
    wreg(0, 12'h01C, 32'h3);
    fork
      for (int i = 0; i < 80; i++) begin @(negedge clk); in8 = 8'(i); end
      wreg(0, 12'h000, 32'h0004_0201);
    join
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0005_000A) $display("FAIL div_status: got err=%b data=%h want 0 0005000a", e, rd); else npass++;
    acc(0, 0, 12'h008, 0, e, rd, lat);
    prev = rd[7:0];
    for (int i = 1; i < 5; i++) begin
      acc(0, 0, 12'h008, 0, e, rd, lat);
      ntot++; if (e !== 0 || rd[7:0] - prev !== 8'd4) $display("FAIL div_spacing[%0d]: got err=%b step=%0d want 0 4", i, e, rd[7:0] - prev); else npass++;
      prev = rd[7:0];
    end
    acc(0, 0, 12'h008, 0, e, rd, lat);
    ntot++; if (e !== 1 || rd !== 0) $display("FAIL div_overread: got err=%b data=%h want 1 0", e, rd); else npass++;
    wreg(0, 12'h01C, 32'h0);
    fork
      for (int i = 0; i < 60; i++) begin @(negedge clk); in8 = 8'(i); end
      wreg(0, 12'h000, 32'h9C40_0201);
    join
    acc(0, 0, 12'h000, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h9C40_0200) $display("FAIL clamp_ctrl: got err=%b data=%h want 0 9c400200", e, rd); else npass++;
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h0010_000A) $display("FAIL clamp_status: got err=%b data=%h want 0 0010000a", e, rd); else npass++;
    acc(0, 0, 12'h008, 0, e, rd, lat);
    first = rd[7:0];
    for (int i = 1; i < 16; i++) acc(0, 0, 12'h008, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd[7:0] - first !== 8'd15) $display("FAIL clamp_span: got err=%b span=%0d want 0 15", e, rd[7:0] - first); else npass++;
  endtask
  task automatic test_abort;
    logic e; logic [31:0] rd; int lat;
    wreg(0, 12'h01C, 32'h3);
    wreg(0, 12'h000, 32'h03E8_0201);
    repeat (10) @(negedge clk);
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd[3:0] !== 4'hC) $display("FAIL abort_before: got err=%b flags=%h want 0 c", e, rd[3:0]); else npass++;
    wreg(0, 12'h000, 32'h2);
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd[2:1] !== 2'b00) $display("FAIL abort_after: got err=%b running_avail=%b want 0 00", e, rd[2:1]); else npass++;
    acc(0, 0, 12'h008, 0, e, rd, lat);
    ntot++; if (e !== 1 || rd !== 0 || lat != 3) $display("FAIL abort_data: got err=%b data=%h lat=%0d want 1 0 3", e, rd, lat); else npass++;
  endtask
  task automatic test_sel;
    logic e; logic [31:0] rd; int lat;
    in40 = '0;
    wreg(1, 12'h00C, 32'h1);
    acc(1, 1, 12'h010, 32'h12, e, rd, lat);
    ntot++; if (e !== 0) $display("FAIL sel_mask_write: got err=%b want 0", e); else npass++;
    wreg(1, 12'h014, 32'h12);
    acc(1, 1, 12'h00C, 32'h2, e, rd, lat);
    ntot++; if (e !== 0) $display("FAIL sel_write: got err=%b want 0", e); else npass++;
    acc(1, 1, 12'h010, 32'hFFFF, e, rd, lat);
    ntot++; if (e !== 1) $display("FAIL sel_range_write: got err=%b want 1", e); else npass++;
    acc(1, 0, 12'h010, 0, e, rd, lat);
    ntot++; if (e !== 1 || rd !== 0) $display("FAIL sel_range_read: got err=%b data=%h want 1 0", e, rd); else npass++;
    wreg(1, 12'h00C, 32'h1);
    acc(1, 0, 12'h010, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 32'h12) $display("FAIL sel_mask_kept: got err=%b data=%h want 0 12", e, rd); else npass++;
    acc(1, 0, 12'h024, 0, e, rd, lat);
    ntot++; if (e !== 1 || rd !== 0) $display("FAIL unmapped: got err=%b data=%h want 1 0", e, rd); else npass++;
    acc(1, 1, 12'h004, 32'h5, e, rd, lat);
    ntot++; if (e !== 1) $display("FAIL ro_write: got err=%b want 1", e); else npass++;
    acc(1, 1, 12'h000, 32'h3, e, rd, lat);
    repeat (4) @(negedge clk);
    acc(1, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd[3:0] !== 4'h4) $display("FAIL start_wins: got err=%b flags=%h want 0 4", e, rd[3:0]); else npass++;
    wreg(1, 12'h000, 32'h2);
  endtask
  task automatic test_reset_mid;
    logic e; logic [31:0] rd; int lat;
    wreg(0, 12'h01C, 32'h3);
    wreg(0, 12'h000, 32'h03E8_0201);
    repeat (10) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    ntot++; if ({ack8, err8, rd8} !== 34'b0) $display("FAIL midreset_outputs: got %b %b %h want 0 0 0", ack8, err8, rd8); else npass++;
    rst = 0;
    acc(0, 0, 12'h020, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 0) $display("FAIL midreset_status: got err=%b data=%h want 0 0", e, rd); else npass++;
    acc(0, 0, 12'h01C, 0, e, rd, lat);
    ntot++; if (e !== 0 || rd !== 0) $display("FAIL midreset_div: got err=%b data=%h want 0 0", e, rd); else npass++;
  endtask
  initial begin
    test_reset;
    test_info;
    test_count;
    test_trans;
    test_edge;
    test_div;
    test_abort;
    test_sel;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
